// File: rtl/hazard_pkg.sv
// Shared encodings and latency helper for the countdown hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MDU  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  localparam int unsigned THR_EARLY  = 1;
  localparam int unsigned THR_NORMAL = 2;

  // Cycles until a producer of the given class can forward to EX; reserved acts as ALU.
  function automatic int unsigned lat(input logic [1:0] cls,
                                      input int unsigned load_lat,
                                      input int unsigned mdu_lat);
    int unsigned r;
    r = 1;
    case (cls)
      2'(CLS_LOAD): r = load_lat + 1;
      2'(CLS_MDU):  r = mdu_lat;
      default:      r = 1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: loadable countdown that sticks at zero.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard driving PC/IF-ID hold and ID/EX bubble.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 4,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iID_Valid,
  input  logic [REG_W-1:0]     iID_NumRs,
  input  logic [REG_W-1:0]     iID_NumRt,
  input  logic                 iID_UseRs,
  input  logic                 iID_UseRt,
  input  logic                 iID_Early,
  input  logic                 iID_WriteEn,
  input  logic [REG_W-1:0]     iID_RegDestino,
  input  logic [1:0]           iID_Class,
  input  logic                 iFlushID,
  input  logic                 iStatClr,
  output logic                 oBlockPC,
  output logic                 oBlockIFID,
  output logic                 oFlushControl,
  output logic [STAT_W-1:0]    oStallCycles,
  output logic [(2**REG_W)-1:0] oPendingMask
);

  localparam int unsigned NREG = 2 ** REG_W;

  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [CNT_W-1:0]  w_lat;
  logic [CNT_W-1:0]  w_thr;
  logic              w_raw_rs;
  logic              w_raw_rt;
  logic              w_waw;
  logic              w_struct;
  logic              w_stall;
  logic              w_issue;
  logic              w_wr;
  logic              w_is_mdu;
  logic [CNT_W-1:0]  r_mdu_busy;
  logic [STAT_W-1:0] r_stat;

  assign w_lat    = CNT_W'(lat(iID_Class, LOAD_LAT, MDU_LAT));
  assign w_thr    = iID_Early ? CNT_W'(THR_EARLY) : CNT_W'(THR_NORMAL);
  assign w_is_mdu = (iID_Class == 2'(CLS_MDU));

  assign w_raw_rs = iID_UseRs && (iID_NumRs != '0) && (w_cnt[iID_NumRs] >= w_thr);
  assign w_raw_rt = iID_UseRt && (iID_NumRt != '0) && (w_cnt[iID_NumRt] >= w_thr);
  // A younger writer may issue once the older one retires no later than it would.
  assign w_waw    = iID_WriteEn && (iID_RegDestino != '0) && (w_cnt[iID_RegDestino] > w_lat);
  assign w_struct = w_is_mdu && (r_mdu_busy != '0);

  assign w_stall = iID_Valid && !iFlushID && (w_raw_rs || w_raw_rt || w_waw || w_struct);
  assign w_issue = iID_Valid && !iFlushID && !w_stall;
  assign w_wr    = w_issue && iID_WriteEn && (iID_RegDestino != '0);

  assign oBlockPC      = w_stall;
  assign oBlockIFID    = w_stall;
  assign oFlushControl = w_stall;

  assign w_cnt[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_entry
    logic w_load;
    assign w_load = w_wr && (iID_RegDestino == REG_W'(g));

    hazard_sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .iCLK    (iCLK),
      .iRST_n  (iRST_n),
      .i_load  (w_load),
      .i_value (w_lat),
      .o_count (w_cnt[g])
    );
  end

  always_comb begin
    oPendingMask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      oPendingMask[i] = (w_cnt[i] != '0);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_mdu_busy <= '0;
    end else if (w_issue && w_is_mdu) begin
      r_mdu_busy <= CNT_W'(MDU_LAT);
    end else if (r_mdu_busy != '0) begin
      r_mdu_busy <= r_mdu_busy - 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_stat <= '0;
    end else if (iStatClr) begin
      r_stat <= '0;
    end else if (w_stall && (r_stat != '1)) begin
      r_stat <= r_stat + 1'b1;
    end
  end

  assign oStallCycles = r_stat;

endmodule
